// File: rtl/input_controller_pkg.sv
// rtl/input_controller_pkg.sv - scancode constants, key/direction types and the key map
package input_controller_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [2:0] {K_NONE, K_LEFT, K_RIGHT, K_DOWN, K_ROT, K_DROP} key_idx_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic {PH_DELAY, PH_REPEAT} phase_t;

  // Arrow keys live behind the E0 prefix; Space is the only plain code we use.
  function automatic key_idx_t map_key(input logic [7:0] code, input logic ext);
    key_idx_t k;
    k = K_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  k = K_LEFT;
        SC_RIGHT: k = K_RIGHT;
        SC_DOWN:  k = K_DOWN;
        SC_UP:    k = K_ROT;
        default:  k = K_NONE;
      endcase
    end else if (code == SC_SPACE) begin
      k = K_DROP;
    end
    return k;
  endfunction

endpackage

// File: rtl/input_controller_parser.sv
// rtl/input_controller_parser.sv - PS/2 set-2 byte parser producing make/break key events
module ps2_scan_parser
  import input_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       evt_valid,
  output logic       evt_make,
  output key_idx_t   evt_key
);

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} pstate_t;

  pstate_t  state, state_nxt;
  logic     emit, emit_make, emit_ext;
  key_idx_t emit_key;

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P_IDLE;
    else     state <= state_nxt;
  end

  // Prefix tracking; a non-prefix byte completes the sequence and emits an event.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_make = 1'b1;
    emit_ext  = 1'b0;
    if (scan_valid) begin
      case (state)
        P_IDLE: begin
          if (scan_code == SC_EXT)      state_nxt = P_EXT;
          else if (scan_code == SC_BRK) state_nxt = P_BRK;
          else                          emit = 1'b1;
        end
        P_EXT: begin
          if (scan_code == SC_BRK) state_nxt = P_EXT_BRK;
          else if (scan_code != SC_EXT) begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = P_IDLE;
          end
        end
        P_BRK: begin
          emit      = 1'b1;
          emit_make = 1'b0;
          state_nxt = P_IDLE;
        end
        P_EXT_BRK: begin
          emit      = 1'b1;
          emit_make = 1'b0;
          emit_ext  = 1'b1;
          state_nxt = P_IDLE;
        end
        default: state_nxt = P_IDLE;
      endcase
    end
    emit_key = map_key(scan_code, emit_ext);
  end

  // Registered event; unmapped codes finish silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_make  <= 1'b0;
      evt_key   <= K_NONE;
    end else begin
      evt_valid <= emit && (emit_key != K_NONE);
      evt_make  <= emit_make;
      evt_key   <= emit ? emit_key : K_NONE;
    end
  end

endmodule

// File: rtl/input_controller.sv
// rtl/input_controller.sv - held-key tracking, DAS/ARR auto-repeat and key strobes
module input_controller
  import input_controller_pkg::*;
#(
  parameter int DAS_DELAY  = 10,
  parameter int ARR_PERIOD = 2,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       tick_game,
  input  logic       enable,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop
);

  localparam logic [CNT_W:0] DAS_W = (CNT_W+1)'(DAS_DELAY);
  localparam logic [CNT_W:0] ARR_W = (CNT_W+1)'(ARR_PERIOD);

  logic       evt_valid, evt_make;
  key_idx_t   evt_key;

  logic       held_l, held_r, held_d, held_rot, held_drop;
  logic       held_l_nxt, held_r_nxt, held_d_nxt, held_rot_nxt, held_drop_nxt;
  dir_t       active_dir, active_nxt;
  phase_t     phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic       pulse_l, pulse_r, pulse_rot, pulse_drop, evt_taken;

  ps2_scan_parser u_parser (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .evt_valid  (evt_valid),
    .evt_make   (evt_make),
    .evt_key    (evt_key)
  );

  // Held flags and auto-repeat state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_l     <= 1'b0;
      held_r     <= 1'b0;
      held_d     <= 1'b0;
      held_rot   <= 1'b0;
      held_drop  <= 1'b0;
      active_dir <= DIR_NONE;
      phase      <= PH_DELAY;
      cnt        <= '0;
    end else begin
      held_l     <= held_l_nxt;
      held_r     <= held_r_nxt;
      held_d     <= held_d_nxt;
      held_rot   <= held_rot_nxt;
      held_drop  <= held_drop_nxt;
      active_dir <= active_nxt;
      phase      <= phase_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Key events first; a tick only counts in a cycle with no accepted key event,
  // so typematic repeats (which are not accepted) never disturb the DAS timing.
  always_comb begin
    held_l_nxt    = held_l;
    held_r_nxt    = held_r;
    held_d_nxt    = held_d;
    held_rot_nxt  = held_rot;
    held_drop_nxt = held_drop;
    active_nxt    = active_dir;
    phase_nxt     = phase;
    cnt_nxt       = cnt;
    pulse_l       = 1'b0;
    pulse_r       = 1'b0;
    pulse_rot     = 1'b0;
    pulse_drop    = 1'b0;
    evt_taken     = 1'b0;
    cnt_inc       = {1'b0, cnt} + (CNT_W+1)'(1);
    if (evt_valid) begin
      case (evt_key)
        K_LEFT: begin
          if (evt_make && !held_l) begin
            held_l_nxt = 1'b1;
            active_nxt = DIR_LEFT;
            pulse_l    = 1'b1;
            cnt_nxt    = '0;
            phase_nxt  = PH_DELAY;
            evt_taken  = 1'b1;
          end else if (!evt_make && held_l) begin
            held_l_nxt = 1'b0;
            evt_taken  = 1'b1;
            if (active_dir == DIR_LEFT) begin
              cnt_nxt    = '0;
              phase_nxt  = PH_DELAY;
              active_nxt = held_r ? DIR_RIGHT : DIR_NONE;
              pulse_r    = held_r;
            end
          end
        end
        K_RIGHT: begin
          if (evt_make && !held_r) begin
            held_r_nxt = 1'b1;
            active_nxt = DIR_RIGHT;
            pulse_r    = 1'b1;
            cnt_nxt    = '0;
            phase_nxt  = PH_DELAY;
            evt_taken  = 1'b1;
          end else if (!evt_make && held_r) begin
            held_r_nxt = 1'b0;
            evt_taken  = 1'b1;
            if (active_dir == DIR_RIGHT) begin
              cnt_nxt    = '0;
              phase_nxt  = PH_DELAY;
              active_nxt = held_l ? DIR_LEFT : DIR_NONE;
              pulse_l    = held_l;
            end
          end
        end
        K_DOWN: begin
          held_d_nxt = evt_make;
          evt_taken  = (evt_make != held_d);
        end
        K_ROT: begin
          if (evt_make != held_rot) begin
            held_rot_nxt = evt_make;
            pulse_rot    = evt_make;
            evt_taken    = 1'b1;
          end
        end
        K_DROP: begin
          if (evt_make != held_drop) begin
            held_drop_nxt = evt_make;
            pulse_drop    = evt_make;
            evt_taken     = 1'b1;
          end
        end
        default: evt_taken = 1'b0;
      endcase
    end
    if (!evt_taken && tick_game && (active_dir != DIR_NONE)) begin
      if (((phase == PH_DELAY) && (cnt_inc == DAS_W)) ||
          ((phase == PH_REPEAT) && (cnt_inc == ARR_W))) begin
        pulse_l   = (active_dir == DIR_LEFT);
        pulse_r   = (active_dir == DIR_RIGHT);
        cnt_nxt   = '0;
        phase_nxt = PH_REPEAT;
      end else begin
        cnt_nxt = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Output gating; key_down follows the Down event in the same cycle as the strobes.
  always_comb begin
    key_left   = enable & pulse_l;
    key_right  = enable & pulse_r;
    key_rotate = enable & pulse_rot;
    key_drop   = enable & pulse_drop;
    key_down   = enable & ((evt_valid && (evt_key == K_DOWN)) ? evt_make : held_d);
  end

endmodule
